rc_ring_out_arb: RTL and testbench
==================================

Name: rc_ring_out_arb

Overview:
- Ring-output arbiter inside the ring controller (RC) of each LOTR tile.
- Shares the single RingOutput*Q502H slot between three sources:
  - ring pass-through traffic not addressed to this core;
  - core-originated requests (C2F_Req*);
  - local-memory responses (F2C_Rsp*).
- Pass-through always wins. The two local sources are buffered in FIFOs and round-robin arbitrated into idle ring slots.

Parameters:
FIFO_DEPTH, 4, entries per local FIFO; power of 2, >=2
PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width (derived, not overridden)

Ports:
QClk  in  1  tile clock
RstQnnnL  in  1  asynchronous reset, active-low
PassValidQ501H  in  1  ring packet to forward unchanged
PassOpcodeQ501H  in  2  forwarded opcode
PassAddressQ501H  in  32  forwarded address
PassDataQ501H  in  32  forwarded data
C2F_ReqValidQ501H  in  1  core request push
C2F_ReqOpcodeQ501H  in  2  core request opcode
C2F_ReqAddressQ501H  in  32  core request address
C2F_ReqDataQ501H  in  32  core request data
C2F_ReqStall  out  1  core FIFO full; core must not push
F2C_RspValidQ501H  in  1  memory response push
F2C_RspOpcodeQ501H  in  2  memory response opcode
F2C_RspAddressQ501H  in  32  response address (requester core id in [31:24])
F2C_RspDataQ501H  in  32  response data
F2C_RspStall  out  1  memory FIFO full
RingOutputValidQ502H  out  1  ring output valid
RingOutputOpcodeQ502H  out  2  ring output opcode
RingOutputAddressQ502H  out  32  ring output address
RingOutputDataQ502H  out  32  ring output data
ArbOverflowQ502H  out  1  sticky: push attempted while full

Behaviour:
Clock and reset
- One clock, QClk. Reset RstQnnnL is asynchronous, active-low.
- On reset: all Ring* outputs are 0. FIFO pointers and counts are 0. Round-robin pointer = CORE. ArbOverflowQ502H = 0.
- Stall outputs are 0 after reset, because the FIFOs are empty.
- Asserting reset mid-operation discards all queued entries. Nothing is replayed.

Output register
- Loaded every cycle. Latency is 1 cycle from Q501H inputs to Q502H outputs.
- Priority 1, PassValidQ501H=1: output = pass packet. No FIFO pops. RR pointer unchanged.
- Priority 2, no pass and both FIFOs non-empty: grant the RR pointer's source, pop its head, toggle the pointer.
- Priority 3, no pass and exactly one FIFO non-empty: grant that source and pop it. The RR pointer is set to the other source.
- No pass and both FIFOs empty: RingOutputValidQ502H=0. Opcode, address and data are driven to 0.

FIFO rules
- Push occurs when Valid=1 and the FIFO is not full. Pop occurs on grant.
- Push and pop in the same cycle: count is unchanged, data ordering is preserved.
- A push into an empty FIFO is not visible to the arbiter until the next cycle. No bypass.
- C2F_ReqStall = (core count == FIFO_DEPTH), combinational from the registered count. F2C_RspStall works the same way.
- A push while full is dropped and sets ArbOverflowQ502H. That flag clears only on reset.
- Pointers wrap modulo FIFO_DEPTH. Count width is PTR_W+1.

Fairness
- Sustained pass traffic starves both FIFOs. This is by design: the ring never stalls.
- With both local sources saturated and no pass traffic, grants alternate exactly CORE, MEM, CORE, ...

Optional Feature:
RC_ARB_PERF_EN
- When defined, adds three 32-bit saturating counters, each exposed on an extra output port:
  - ArbCoreGrantCnt
  - ArbMemGrantCnt
  - ArbBlockedCnt: cycles where pass-through won while a FIFO was non-empty.
- Counters reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, these ports and all counter logic are absent. Arbitration is identical with or without the macro.

Decomposition:
- lotr_pkg holds:
  - the opcode enum t_ring_opcode: RD=2'b00, RD_RSP=2'b01, WR=2'b10, WR_RSP=2'b11;
  - the packed struct t_ring_pkt {opcode, address, data};
  - the RR source enum {CORE, MEM}.
- One sub-module, rc_sync_fifo:
  - parameterised by depth and data type;
  - asynchronous active-low reset;
  - outputs full, empty and count;
  - instantiated twice.

Test Plan:
1. Reset with RstQnnnL=0 mid-burst, with 3 entries queued -> all outputs are 0 immediately without a clock edge. After release, the FIFOs are empty and Stall=0.
2. Single core push {WR, 0x0100_0004, 0xDEAD_BEEF} with no pass traffic -> output valid exactly 2 cycles after the push cycle, with identical fields.
3. Pass traffic valid 5 consecutive cycles while both FIFOs hold 2 entries each -> pass packets appear in order with 1-cycle latency. Then grants follow CORE, MEM, CORE, MEM. ArbBlockedCnt=5 when perf is enabled.
4. Push 4 core requests with no idle slot -> C2F_ReqStall=1 after the 4th. A 5th push is dropped and ArbOverflowQ502H=1. Remaining order is FIFO.
5. Full FIFO with simultaneous push and pop on a grant cycle -> Stall stays 1, the push is not accepted, and no overflow is flagged.
6. Memory responses only: 3 pushes of RD_RSP with data 1, 2, 3 -> outputs in order 1, 2, 3 on consecutive cycles. The RR pointer ends at CORE.

Source files
------------

// File: rtl/lotr_pkg.sv
// Shared ring types for the LOTR tile: opcodes, ring packet payload, arbiter source select.
package lotr_pkg;

    localparam int unsigned OPC_W      = 2;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned PERF_CNT_W = 32;

    typedef enum logic [OPC_W-1:0] {
        RD     = 2'b00,
        RD_RSP = 2'b01,
        WR     = 2'b10,
        WR_RSP = 2'b11
    } t_ring_opcode;

    typedef struct packed {
        t_ring_opcode        opcode;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W-1:0]   data;
    } t_ring_pkt;

    typedef enum logic {
        CORE = 1'b0,
        MEM  = 1'b1
    } t_rr_src;

    // Saturating increment used by the optional performance counters.
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] val,
                                                     input logic                  en);
        return (en && (val != '1)) ? val + PERF_CNT_W'(1) : val;
    endfunction

endpackage

// File: rtl/rc_sync_fifo.sv
// Single-clock FIFO with registered count; no write-to-read bypass.
module rc_sync_fifo #(
    parameter  int unsigned DEPTH  = 4,
    parameter  type         T_DATA = lotr_pkg::t_ring_pkt,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  T_DATA            push_data,
    input  logic             pop,
    output T_DATA            head_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [CNT_W-1:0] count
);

    T_DATA             mem_q [DEPTH];
    T_DATA             mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        full_c   = (count_q == CNT_W'(DEPTH));
        empty_c  = (count_q == '0);
        do_push  = push && !full_c;
        do_pop   = pop && !empty_c;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head_c = mem_q[rd_ptr_q];
    assign count  = count_q;

endmodule

// File: rtl/rc_ring_out_arb.sv
// Ring-output arbiter: pass-through traffic first, then round-robin between core and memory FIFOs.
// Define RC_ARB_PERF_EN to add saturating grant/blocked performance counters.
module rc_ring_out_arb
    import lotr_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic        QClk,
    input  logic        RstQnnnL,
    input  logic        PassValidQ501H,
    input  logic [1:0]  PassOpcodeQ501H,
    input  logic [31:0] PassAddressQ501H,
    input  logic [31:0] PassDataQ501H,
    input  logic        C2F_ReqValidQ501H,
    input  logic [1:0]  C2F_ReqOpcodeQ501H,
    input  logic [31:0] C2F_ReqAddressQ501H,
    input  logic [31:0] C2F_ReqDataQ501H,
    output logic        C2F_ReqStall,
    input  logic        F2C_RspValidQ501H,
    input  logic [1:0]  F2C_RspOpcodeQ501H,
    input  logic [31:0] F2C_RspAddressQ501H,
    input  logic [31:0] F2C_RspDataQ501H,
    output logic        F2C_RspStall,
    output logic        RingOutputValidQ502H,
    output logic [1:0]  RingOutputOpcodeQ502H,
    output logic [31:0] RingOutputAddressQ502H,
    output logic [31:0] RingOutputDataQ502H,
    output logic        ArbOverflowQ502H
`ifdef RC_ARB_PERF_EN
    ,
    output logic [31:0] ArbCoreGrantCnt,
    output logic [31:0] ArbMemGrantCnt,
    output logic [31:0] ArbBlockedCnt
`endif
);

    t_ring_pkt        pass_pkt, core_pkt, mem_pkt;
    t_ring_pkt        core_head_c, mem_head_c;
    logic             core_full_c, core_empty_c, mem_full_c, mem_empty_c;
    logic [PTR_W:0]   core_count, mem_count;
    logic             core_pop_c, mem_pop_c;
    t_rr_src          rr_q, rr_d;
    logic             out_vld_q, out_vld_d;
    t_ring_pkt        out_pkt_q, out_pkt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        pass_pkt = '{opcode: t_ring_opcode'(PassOpcodeQ501H),
                     address: PassAddressQ501H, data: PassDataQ501H};
        core_pkt = '{opcode: t_ring_opcode'(C2F_ReqOpcodeQ501H),
                     address: C2F_ReqAddressQ501H, data: C2F_ReqDataQ501H};
        mem_pkt  = '{opcode: t_ring_opcode'(F2C_RspOpcodeQ501H),
                     address: F2C_RspAddressQ501H, data: F2C_RspDataQ501H};
    end

    rc_sync_fifo #(.DEPTH(FIFO_DEPTH), .T_DATA(t_ring_pkt)) u_core_fifo (
        .clk       (QClk),
        .rst_n     (RstQnnnL),
        .push      (C2F_ReqValidQ501H),
        .push_data (core_pkt),
        .pop       (core_pop_c),
        .head_c    (core_head_c),
        .full_c    (core_full_c),
        .empty_c   (core_empty_c),
        .count     (core_count)
    );

    rc_sync_fifo #(.DEPTH(FIFO_DEPTH), .T_DATA(t_ring_pkt)) u_mem_fifo (
        .clk       (QClk),
        .rst_n     (RstQnnnL),
        .push      (F2C_RspValidQ501H),
        .push_data (mem_pkt),
        .pop       (mem_pop_c),
        .head_c    (mem_head_c),
        .full_c    (mem_full_c),
        .empty_c   (mem_empty_c),
        .count     (mem_count)
    );

    // Slot selection; the RR pointer only moves when a local source is granted.
    always_comb begin
        out_vld_d  = 1'b0;
        out_pkt_d  = '0;
        core_pop_c = 1'b0;
        mem_pop_c  = 1'b0;
        rr_d       = rr_q;
        if (PassValidQ501H) begin
            out_vld_d = 1'b1;
            out_pkt_d = pass_pkt;
        end else if (!core_empty_c && !mem_empty_c) begin
            out_vld_d = 1'b1;
            if (rr_q == CORE) begin
                core_pop_c = 1'b1;
                out_pkt_d  = core_head_c;
                rr_d       = MEM;
            end else begin
                mem_pop_c  = 1'b1;
                out_pkt_d  = mem_head_c;
                rr_d       = CORE;
            end
        end else if (!core_empty_c) begin
            out_vld_d  = 1'b1;
            core_pop_c = 1'b1;
            out_pkt_d  = core_head_c;
            rr_d       = MEM;
        end else if (!mem_empty_c) begin
            out_vld_d  = 1'b1;
            mem_pop_c  = 1'b1;
            out_pkt_d  = mem_head_c;
            rr_d       = CORE;
        end
        // A push refused on a full FIFO is only an overflow if no slot is freed that cycle.
        ovf_d = ovf_q
              | (C2F_ReqValidQ501H && core_full_c && !core_pop_c)
              | (F2C_RspValidQ501H && mem_full_c && !mem_pop_c);
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            rr_q      <= CORE;
            out_vld_q <= 1'b0;
            out_pkt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            out_vld_q <= out_vld_d;
            out_pkt_q <= out_pkt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign RingOutputValidQ502H   = out_vld_q;
    assign RingOutputOpcodeQ502H  = out_pkt_q.opcode;
    assign RingOutputAddressQ502H = out_pkt_q.address;
    assign RingOutputDataQ502H    = out_pkt_q.data;
    assign ArbOverflowQ502H       = ovf_q;
    assign C2F_ReqStall           = (core_count == (PTR_W+1)'(FIFO_DEPTH));
    assign F2C_RspStall           = (mem_count == (PTR_W+1)'(FIFO_DEPTH));

`ifdef RC_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] core_gnt_cnt_q, core_gnt_cnt_d;
    logic [PERF_CNT_W-1:0] mem_gnt_cnt_q, mem_gnt_cnt_d;
    logic [PERF_CNT_W-1:0] blocked_cnt_q, blocked_cnt_d;

    always_comb begin
        core_gnt_cnt_d = sat_inc(core_gnt_cnt_q, core_pop_c);
        mem_gnt_cnt_d  = sat_inc(mem_gnt_cnt_q, mem_pop_c);
        blocked_cnt_d  = sat_inc(blocked_cnt_q,
                                 PassValidQ501H && (!core_empty_c || !mem_empty_c));
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            core_gnt_cnt_q <= '0;
            mem_gnt_cnt_q  <= '0;
            blocked_cnt_q  <= '0;
        end else begin
            core_gnt_cnt_q <= core_gnt_cnt_d;
            mem_gnt_cnt_q  <= mem_gnt_cnt_d;
            blocked_cnt_q  <= blocked_cnt_d;
        end
    end

    assign ArbCoreGrantCnt = core_gnt_cnt_q;
    assign ArbMemGrantCnt  = mem_gnt_cnt_q;
    assign ArbBlockedCnt   = blocked_cnt_q;
`endif

endmodule

// File: tb/tb_rc_ring_out_arb.sv
// Directed, table-driven bench for rc_ring_out_arb with hand-computed expectations.
module tb_rc_ring_out_arb;
    import lotr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pass_v, c_v, m_v;
    logic [1:0]  pass_op, c_op, m_op;
    logic [31:0] pass_a, pass_d, c_a, c_d, m_a, m_d;
    logic        c_stall, m_stall, out_v, ovf;
    logic [1:0]  out_op;
    logic [31:0] out_a, out_d;
`ifdef RC_ARB_PERF_EN
    logic [31:0] core_cnt, mem_cnt, blk_cnt;
    logic [31:0] blk_base;
`endif

    always #5 clk = ~clk;

    rc_ring_out_arb #(.FIFO_DEPTH(4)) dut (
        .QClk                   (clk),
        .RstQnnnL               (rst_n),
        .PassValidQ501H         (pass_v),
        .PassOpcodeQ501H        (pass_op),
        .PassAddressQ501H       (pass_a),
        .PassDataQ501H          (pass_d),
        .C2F_ReqValidQ501H      (c_v),
        .C2F_ReqOpcodeQ501H     (c_op),
        .C2F_ReqAddressQ501H    (c_a),
        .C2F_ReqDataQ501H       (c_d),
        .C2F_ReqStall           (c_stall),
        .F2C_RspValidQ501H      (m_v),
        .F2C_RspOpcodeQ501H     (m_op),
        .F2C_RspAddressQ501H    (m_a),
        .F2C_RspDataQ501H       (m_d),
        .F2C_RspStall           (m_stall),
        .RingOutputValidQ502H   (out_v),
        .RingOutputOpcodeQ502H  (out_op),
        .RingOutputAddressQ502H (out_a),
        .RingOutputDataQ502H    (out_d),
        .ArbOverflowQ502H       (ovf)
`ifdef RC_ARB_PERF_EN
        ,
        .ArbCoreGrantCnt        (core_cnt),
        .ArbMemGrantCnt         (mem_cnt),
        .ArbBlockedCnt          (blk_cnt)
`endif
    );

    typedef struct packed {
        logic      pv;
        t_ring_pkt pp;
        logic      cv;
        t_ring_pkt cp;
        logic      mv;
        t_ring_pkt mp;
        logic      ev;
        t_ring_pkt ep;
        logic      ecs;
        logic      ems;
        logic      eovf;
    } vec_t;

    localparam t_ring_pkt Z = '0;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic t_ring_pkt pk(input t_ring_opcode op, input logic [31:0] a,
                                     input logic [31:0] d);
        t_ring_pkt p;
        p.opcode  = op;
        p.address = a;
        p.data    = d;
        return p;
    endfunction

    task automatic add(input logic pv, input t_ring_pkt pp, input logic cv, input t_ring_pkt cp,
                       input logic mv, input t_ring_pkt mp, input logic ev, input t_ring_pkt ep,
                       input logic ecs, input logic ems, input logic eovf);
        vec_t v;
        v = '{pv: pv, pp: pp, cv: cv, cp: cp, mv: mv, mp: mp,
              ev: ev, ep: ep, ecs: ecs, ems: ems, eovf: eovf};
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pass_v = v.pv; pass_op = v.pp.opcode; pass_a = v.pp.address; pass_d = v.pp.data;
        c_v    = v.cv; c_op    = v.cp.opcode; c_a    = v.cp.address; c_d    = v.cp.data;
        m_v    = v.mv; m_op    = v.mp.opcode; m_a    = v.mp.address; m_d    = v.mp.data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(tbl[i]);
            step();
            chk($sformatf("row%0d valid", i), 32'(out_v), 32'(tbl[i].ev));
            chk($sformatf("row%0d opcode", i), 32'(out_op), 32'(tbl[i].ep.opcode));
            chk($sformatf("row%0d addr", i), out_a, tbl[i].ep.address);
            chk($sformatf("row%0d data", i), out_d, tbl[i].ep.data);
            chk($sformatf("row%0d c_stall", i), 32'(c_stall), 32'(tbl[i].ecs));
            chk($sformatf("row%0d m_stall", i), 32'(m_stall), 32'(tbl[i].ems));
            chk($sformatf("row%0d overflow", i), 32'(ovf), 32'(tbl[i].eovf));
        end
    endtask

    task automatic build_table();
        // rows 0-2: single core request, visible two edges after the push
        add(0, Z, 1, pk(WR, 32'h0100_0004, 32'hDEAD_BEEF), 0, Z, 0, Z, 0, 0, 0);
        add(0, Z, 0, Z, 0, Z, 1, pk(WR, 32'h0100_0004, 32'hDEAD_BEEF), 0, 0, 0);
        add(0, Z, 0, Z, 0, Z, 0, Z, 0, 0, 0);
        // rows 3-7: memory responses 1,2,3 back to back; RR ends at CORE
        add(0, Z, 0, Z, 1, pk(RD_RSP, 32'h0200_0000, 32'd1), 0, Z, 0, 0, 0);
        add(0, Z, 0, Z, 1, pk(RD_RSP, 32'h0200_0000, 32'd2), 1, pk(RD_RSP, 32'h0200_0000, 32'd1), 0, 0, 0);
        add(0, Z, 0, Z, 1, pk(RD_RSP, 32'h0200_0000, 32'd3), 1, pk(RD_RSP, 32'h0200_0000, 32'd2), 0, 0, 0);
        add(0, Z, 0, Z, 0, Z, 1, pk(RD_RSP, 32'h0200_0000, 32'd3), 0, 0, 0);
        add(0, Z, 0, Z, 0, Z, 0, Z, 0, 0, 0);
        // rows 8-9: fill both FIFOs with two entries under pass traffic
        for (int i = 0; i < 2; i++)
            add(1, pk(RD, 32'hA000_0000 + 32'(i), 32'hF0 + 32'(i)),
                1, pk(WR, 32'h100 + 32'(i), 32'hC0 + 32'(i)),
                1, pk(RD_RSP, 32'h200 + 32'(i), 32'hE0 + 32'(i)),
                1, pk(RD, 32'hA000_0000 + 32'(i), 32'hF0 + 32'(i)), 0, 0, 0);
        // rows 10-14: five pass packets, FIFOs starved
        for (int i = 0; i < 5; i++)
            add(1, pk(WR_RSP, 32'hB000_0000 + 32'(i), 32'h5A00 + 32'(i)), 0, Z, 0, Z,
                1, pk(WR_RSP, 32'hB000_0000 + 32'(i), 32'h5A00 + 32'(i)), 0, 0, 0);
        // rows 15-19: drain alternates CORE, MEM, CORE, MEM
        add(0, Z, 0, Z, 0, Z, 1, pk(WR, 32'h100, 32'hC0), 0, 0, 0);
        add(0, Z, 0, Z, 0, Z, 1, pk(RD_RSP, 32'h200, 32'hE0), 0, 0, 0);
        add(0, Z, 0, Z, 0, Z, 1, pk(WR, 32'h101, 32'hC1), 0, 0, 0);
        add(0, Z, 0, Z, 0, Z, 1, pk(RD_RSP, 32'h201, 32'hE1), 0, 0, 0);
        add(0, Z, 0, Z, 0, Z, 0, Z, 0, 0, 0);
        // rows 20-23: four core pushes with no idle slot; stall after the fourth
        for (int i = 0; i < 4; i++)
            add(1, pk(RD, 32'hC000_0000 + 32'(i), 32'(i)), 1, pk(WR, 32'h300 + 32'(i), 32'h900 + 32'(i)),
                0, Z, 1, pk(RD, 32'hC000_0000 + 32'(i), 32'(i)), (i == 3), 0, 0);
        // row 24: full FIFO, push coincides with pop -> push refused, no overflow
        add(0, Z, 1, pk(WR, 32'h305, 32'h905), 0, Z, 1, pk(WR, 32'h300, 32'h900), 0, 0, 0);
        // rows 25-26: refill to full, then a push while full overflows
        add(1, pk(RD, 32'hC000_0004, 32'd4), 1, pk(WR, 32'h306, 32'h906), 0, Z,
            1, pk(RD, 32'hC000_0004, 32'd4), 1, 0, 0);
        add(1, pk(RD, 32'hC000_0005, 32'd5), 1, pk(WR, 32'h307, 32'h907), 0, Z,
            1, pk(RD, 32'hC000_0005, 32'd5), 1, 0, 1);
        // rows 27-31: remaining order Q1, Q2, Q3, Q6
        add(0, Z, 0, Z, 0, Z, 1, pk(WR, 32'h301, 32'h901), 0, 0, 1);
        add(0, Z, 0, Z, 0, Z, 1, pk(WR, 32'h302, 32'h902), 0, 0, 1);
        add(0, Z, 0, Z, 0, Z, 1, pk(WR, 32'h303, 32'h903), 0, 0, 1);
        add(0, Z, 0, Z, 0, Z, 1, pk(WR, 32'h306, 32'h906), 0, 0, 1);
        add(0, Z, 0, Z, 0, Z, 0, Z, 0, 0, 1);
        // rows 32-34: three queued core entries ahead of a mid-burst reset
        for (int i = 0; i < 3; i++)
            add(1, pk(WR, 32'hD000_0000 + 32'(i), 32'h77 + 32'(i)), 1, pk(RD, 32'h400 + 32'(i), 32'h800 + 32'(i)),
                0, Z, 1, pk(WR, 32'hD000_0000 + 32'(i), 32'h77 + 32'(i)), 0, 0, 1);
        // rows 35-43 (after reset): fill memory FIFO to full, then drain in order
        for (int i = 0; i < 4; i++)
            add(1, pk(RD, 32'hE000_0000 + 32'(i), 32'(i)), 0, Z,
                1, pk(RD_RSP, 32'h0700_0000 + 32'(i), 32'h600 + 32'(i)),
                1, pk(RD, 32'hE000_0000 + 32'(i), 32'(i)), 0, (i == 3), 0);
        for (int i = 0; i < 4; i++)
            add(0, Z, 0, Z, 0, Z, 1, pk(RD_RSP, 32'h0700_0000 + 32'(i), 32'h600 + 32'(i)), 0, 0, 0);
        add(0, Z, 0, Z, 0, Z, 0, Z, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        idle  = '0;
        rst_n = 1'b0;
        drive(idle);
        build_table();
        #1;
        chk("reset valid", 32'(out_v), 32'd0);
        chk("reset overflow", 32'(ovf), 32'd0);
        chk("reset c_stall", 32'(c_stall), 32'd0);
        chk("reset m_stall", 32'(m_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_rows(0, 7);
        run_rows(8, 9);
`ifdef RC_ARB_PERF_EN
        blk_base = blk_cnt;
`endif
        run_rows(10, 14);
`ifdef RC_ARB_PERF_EN
        chk("perf blocked delta", blk_cnt - blk_base, 32'd5);
`endif
        run_rows(15, 19);
`ifdef RC_ARB_PERF_EN
        chk("perf core grants", core_cnt, 32'd3);
        chk("perf mem grants", mem_cnt, 32'd5);
`endif
        run_rows(20, 34);

        // Mid-burst asynchronous reset with three core entries queued
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 32'(out_v), 32'd0);
        chk("async rst opcode", 32'(out_op), 32'd0);
        chk("async rst addr", out_a, 32'd0);
        chk("async rst data", out_d, 32'd0);
        chk("async rst overflow", 32'(ovf), 32'd0);
        chk("async rst c_stall", 32'(c_stall), 32'd0);
        drive(idle);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("post rst valid%0d", i), 32'(out_v), 32'd0);
            chk($sformatf("post rst c_stall%0d", i), 32'(c_stall), 32'd0);
            chk($sformatf("post rst overflow%0d", i), 32'(ovf), 32'd0);
        end

        run_rows(35, 43);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
